aibio_dll_code_ctrl: RTL and testbench

//  Digital delay-code controller for the RX DLL; sits directly upstream of the 4-bit +1 code stage.

---
 rtl/aibio_dll_pkg.sv | 19 +
 rtl/aibio_dll_vote_filter.sv | 46 ++++
 rtl/aibio_dll_code_ctrl.sv | 140 ++++++++++++++
 tb/tb_aibio_dll_code_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibio_dll_pkg.sv
// Shared definitions for the RX DLL delay-code controller:
// controller state codes, step-direction type and code limits.
package aibio_dll_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } step_dir_t;

    localparam logic [3:0] CODE_MAX = 4'd15;
    localparam logic [3:0] CODE_MIN = 4'd0;

endpackage

// File: rtl/aibio_dll_vote_filter.sv
// Signed phase-detector vote integrator. A vote that brings the
// accumulator to +/-FILT_TH produces a combinational one-cycle step
// request and clears the accumulator on the same clock edge.
module aibio_dll_vote_filter #(
    parameter int FILT_TH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic vld,
    input  logic up,
    input  logic dn,
    output logic step_up,
    output logic step_dn
);

    localparam logic signed [4:0] ACC_HI = 5'(FILT_TH - 1);
    localparam logic signed [4:0] ACC_LO = 5'(1 - FILT_TH);

    logic signed [4:0] acc;
    logic              vote_up;
    logic              vote_dn;

    // Decode a single-direction vote and detect the decisive one
    always_comb begin
        vote_up = vld & up & ~dn;
        vote_dn = vld & dn & ~up;
        step_up = en & vote_up & (acc == ACC_HI);
        step_dn = en & vote_dn & (acc == ACC_LO);
    end

    // Integrate votes; clear on a step or when the filter is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr || step_up || step_dn) begin
            acc <= '0;
        end else if (en && vote_up) begin
            acc <= acc + 5'sd1;
        end else if (en && vote_dn) begin
            acc <= acc - 5'sd1;
        end
    end

endmodule

// File: rtl/aibio_dll_code_ctrl.sv
// RX DLL delay-code controller: integrates phase-detector votes, steps a
// saturating delay code and declares lock after enough alternating steps.
// Optional code override ports are added when AIBIO_DLL_CODE_OVRD_EN is defined.
module aibio_dll_code_ctrl
    import aibio_dll_pkg::*;
#(
    parameter int CODE_W   = 4,
    parameter int FILT_TH  = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              vddcq,
    input  logic              vss,
    input  logic              i_en,
    input  logic [CODE_W-1:0] i_code_init,
    input  logic              i_pd_vld,
    input  logic              i_pd_up,
    input  logic              i_pd_dn,
`ifdef AIBIO_DLL_CODE_OVRD_EN
    input  logic              i_ovrd_en,
    input  logic [CODE_W-1:0] i_ovrd_code,
`endif
    output logic [CODE_W-1:0] o_code,
    output logic              o_code_vld,
    output logic              o_lock,
    output logic              o_sat_hi,
    output logic              o_sat_lo
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [1:0]        state;
    logic [CODE_W-1:0] code;
    logic              sat_hi;
    logic              sat_lo;
    logic [3:0]        lock_cnt;
    step_dir_t         last_dir;

    logic              ovrd;
    logic              tracking;
    logic              active;
    logic              step_up;
    logic              step_dn;
    step_dir_t         dir;
    logic              sat_step;
    logic              alternate;
    logic [3:0]        cnt_inc;
    logic [3:0]        cnt_next;
    logic              unused_supply;

    assign unused_supply = vddcq ^ vss;

`ifdef AIBIO_DLL_CODE_OVRD_EN
    assign ovrd = i_ovrd_en;
`else
    assign ovrd = 1'b0;
`endif

    assign tracking = (state == ST_TRACK) || (state == ST_LOCKED);
    assign active   = tracking & i_en & ~ovrd;

    aibio_dll_vote_filter #(
        .FILT_TH (FILT_TH)
    ) u_filter (
        .clk     (i_clk),
        .rst_n   (i_rstb),
        .en      (active),
        .clr     (~active),
        .vld     (i_pd_vld),
        .up      (i_pd_up),
        .dn      (i_pd_dn),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    // Classify the pending step: saturating or not, alternating or repeated
    always_comb begin
        dir       = step_up ? DIR_UP : DIR_DN;
        sat_step  = (step_up && (code == CODE_MAX)) || (step_dn && (code == CODE_MIN));
        alternate = (last_dir != DIR_NONE) && (dir != last_dir);
        cnt_inc   = (lock_cnt >= LOCK_TGT) ? LOCK_TGT : lock_cnt + 4'd1;
        cnt_next  = alternate ? cnt_inc : 4'd1;
    end

    // Controller state, code register, saturation flags and lock counter
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state    <= ST_IDLE;
            code     <= '0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
            lock_cnt <= 4'd0;
            last_dir <= DIR_NONE;
        end else if (ovrd) begin
`ifdef AIBIO_DLL_CODE_OVRD_EN
            code     <= i_ovrd_code;
`endif
            state    <= ST_IDLE;
        end else if (!i_en) begin
            state    <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    code     <= i_code_init;
                    sat_hi   <= 1'b0;
                    sat_lo   <= 1'b0;
                    lock_cnt <= 4'd0;
                    last_dir <= DIR_NONE;
                    state    <= ST_TRACK;
                end
                default: begin
                    if (step_up || step_dn) begin
                        if (sat_step) begin
                            if (step_up) sat_hi <= 1'b1;
                            if (step_dn) sat_lo <= 1'b1;
                            lock_cnt <= 4'd0;
                            state    <= ST_TRACK;
                        end else begin
                            code     <= step_up ? code + CODE_W'(1) : code - CODE_W'(1);
                            last_dir <= dir;
                            lock_cnt <= cnt_next;
                            state    <= (cnt_next >= LOCK_TGT) ? ST_LOCKED : ST_TRACK;
                        end
                    end
                end
            endcase
        end
    end

    assign o_code     = code;
    assign o_code_vld = tracking;
    assign o_lock     = (state == ST_LOCKED);
    assign o_sat_hi   = sat_hi;
    assign o_sat_lo   = sat_lo;

endmodule

// File: tb/tb_aibio_dll_code_ctrl.sv
// Self-checking bench for aibio_dll_code_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model of the controller.
// Define AIBIO_DLL_CODE_OVRD_EN to also exercise the override ports.
module tb_aibio_dll_code_ctrl;

    localparam int TH   = 4;
    localparam int LOCK = 8;

    logic       i_clk;
    logic       i_rstb;
    logic       vddcq;
    logic       vss;
    logic       i_en;
    logic [3:0] i_code_init;
    logic       i_pd_vld;
    logic       i_pd_up;
    logic       i_pd_dn;
`ifdef AIBIO_DLL_CODE_OVRD_EN
    logic       i_ovrd_en;
    logic [3:0] i_ovrd_code;
`endif
    logic [3:0] o_code;
    logic       o_code_vld;
    logic       o_lock;
    logic       o_sat_hi;
    logic       o_sat_lo;

    int tests_run;
    int tests_failed;

    // Behavioural model: phase 0 idle, 1 load, 2 tracking
    int m_phase;
    int m_code;
    int m_acc;
    int m_run;
    int m_prev;
    bit m_locked;
    bit m_sat_hi;
    bit m_sat_lo;

    aibio_dll_code_ctrl #(
        .CODE_W   (4),
        .FILT_TH  (TH),
        .LOCK_CNT (LOCK)
    ) dut (
        .i_clk       (i_clk),
        .i_rstb      (i_rstb),
        .vddcq       (vddcq),
        .vss         (vss),
        .i_en        (i_en),
        .i_code_init (i_code_init),
        .i_pd_vld    (i_pd_vld),
        .i_pd_up     (i_pd_up),
        .i_pd_dn     (i_pd_dn),
`ifdef AIBIO_DLL_CODE_OVRD_EN
        .i_ovrd_en   (i_ovrd_en),
        .i_ovrd_code (i_ovrd_code),
`endif
        .o_code      (o_code),
        .o_code_vld  (o_code_vld),
        .o_lock      (o_lock),
        .o_sat_hi    (o_sat_hi),
        .o_sat_lo    (o_sat_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_phase = 0; m_code = 0; m_acc = 0; m_run = 0; m_prev = 0;
        m_locked = 0; m_sat_hi = 0; m_sat_lo = 0;
    endtask

    task automatic model_step();
        int d;
        int stp;
        bit ovrd;
        ovrd = 0;
`ifdef AIBIO_DLL_CODE_OVRD_EN
        ovrd = i_ovrd_en;
`endif
        if (!i_rstb) begin
            model_reset();
        end else if (ovrd) begin
`ifdef AIBIO_DLL_CODE_OVRD_EN
            m_code = int'(i_ovrd_code);
`endif
            m_phase = 0; m_acc = 0; m_locked = 0;
        end else if (!i_en) begin
            m_phase = 0; m_acc = 0; m_locked = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_code = int'(i_code_init);
            m_acc = 0; m_run = 0; m_prev = 0;
            m_sat_hi = 0; m_sat_lo = 0; m_locked = 0;
            m_phase = 2;
        end else begin
            d = 0;
            if (i_pd_vld && i_pd_up && !i_pd_dn) d = 1;
            if (i_pd_vld && i_pd_dn && !i_pd_up) d = -1;
            m_acc = m_acc + d;
            stp = 0;
            if (m_acc >= TH)  stp = 1;
            if (m_acc <= -TH) stp = -1;
            if (stp != 0) begin
                m_acc = 0;
                if (m_code + stp > 15 || m_code + stp < 0) begin
                    if (stp > 0) m_sat_hi = 1; else m_sat_lo = 1;
                    m_run = 0;
                    m_locked = 0;
                end else begin
                    m_code = m_code + stp;
                    if (m_prev == -stp) m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                    else m_run = 1;
                    m_prev = stp;
                    m_locked = (m_run >= LOCK);
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] c;
        c = 4'(m_code);
        return {c, (m_phase == 2), m_locked, m_sat_hi, m_sat_lo};
    endfunction

    task automatic do_cycle();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic step_votes(input int n, input logic up, input logic dn);
        for (int i = 0; i < n; i++) begin
            i_pd_vld = 1'b1; i_pd_up = up; i_pd_dn = dn;
            do_cycle();
        end
        i_pd_vld = 1'b0; i_pd_up = 1'b0; i_pd_dn = 1'b0;
    endtask

    task automatic start(input logic [3:0] init);
        i_en = 1'b0;
        do_cycle();
        i_code_init = init;
        i_en = 1'b1;
        do_cycle();
        do_cycle();
    endtask

    // Reset at start-up: every output low
    task automatic test_reset();
        i_rstb = 1'b0;
        #1;
        tests_run++;
        if ({o_code, o_code_vld, o_lock, o_sat_hi, o_sat_lo} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 00", {o_code, o_code_vld, o_lock, o_sat_hi, o_sat_lo});
        end
        do_cycle();
        i_rstb = 1'b1;
        do_cycle();
        tests_run++;
        if (o_code_vld !== 1'b0 || o_code !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got code %0d vld %b expected 0 0", o_code, o_code_vld);
        end
    endtask

    // Four up votes from code 7 give exactly one step to 8
    task automatic test_step_up();
        start(4'd7);
        tests_run++;
        if (o_code !== 4'd7 || o_code_vld !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_code: got code %0d vld %b expected 7 1", o_code, o_code_vld);
        end
        step_votes(3, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL pre_step_code: got %0d expected 7", o_code);
        end
        step_votes(1, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd8) begin
            tests_failed++;
            $display("[TB] FAIL step_up_code: got %0d expected 8", o_code);
        end
        step_votes(3, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd8) begin
            tests_failed++;
            $display("[TB] FAIL acc_cleared: got %0d expected 8", o_code);
        end
    endtask

    // Saturation at both ends and votes that must not count
    task automatic test_saturation();
        start(4'd15);
        step_votes(4, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd15 || o_sat_hi !== 1'b1 || o_lock !== 1'b0 || o_sat_lo !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sat_hi: got code %0d hi %b lo %b lock %b expected 15 1 0 0", o_code, o_sat_hi, o_sat_lo, o_lock);
        end
        step_votes(3, 1'b0, 1'b1);
        step_votes(2, 1'b1, 1'b1);
        i_pd_up = 1'b0; i_pd_dn = 1'b1;
        do_cycle();
        i_pd_dn = 1'b0;
        tests_run++;
        if (o_code !== 4'd15) begin
            tests_failed++;
            $display("[TB] FAIL both_votes_ignored: got %0d expected 15", o_code);
        end
        step_votes(1, 1'b0, 1'b1);
        tests_run++;
        if (o_code !== 4'd14 || o_sat_hi !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fourth_dn_step: got code %0d hi %b expected 14 1", o_code, o_sat_hi);
        end
        start(4'd0);
        tests_run++;
        if (o_sat_hi !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sat_clear_on_load: got %b expected 0", o_sat_hi);
        end
        step_votes(4, 1'b0, 1'b1);
        tests_run++;
        if (o_code !== 4'd0 || o_sat_lo !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_lo: got code %0d lo %b expected 0 1", o_code, o_sat_lo);
        end
    endtask

    // Eight alternating steps lock; two same-direction steps unlock
    task automatic test_lock();
        start(4'd5);
        for (int s = 0; s < 8; s++) begin
            step_votes(4, (s % 2) == 0, (s % 2) == 1);
            tests_run++;
            if (o_lock !== (s == 7)) begin
                tests_failed++;
                $display("[TB] FAIL lock_step%0d: got %b expected %b", s, o_lock, (s == 7));
            end
        end
        step_votes(4, 1'b1, 1'b0);
        tests_run++;
        if (o_lock !== 1'b1 || o_code !== 4'd6) begin
            tests_failed++;
            $display("[TB] FAIL lock_hold: got lock %b code %0d expected 1 6", o_lock, o_code);
        end
        step_votes(4, 1'b1, 1'b0);
        tests_run++;
        if (o_lock !== 1'b0 || o_code !== 4'd7 || o_code_vld !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL unlock: got lock %b code %0d vld %b expected 0 7 1", o_lock, o_code, o_code_vld);
        end
    endtask

    // Enable drop freezes the code; re-enable reloads from init
    task automatic test_enable_drop();
        start(4'd11);
        i_en = 1'b0;
        do_cycle();
        step_votes(5, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd11 || o_code_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL en_drop_hold: got code %0d vld %b expected 11 0", o_code, o_code_vld);
        end
        i_code_init = 4'd3;
        i_en = 1'b1;
        do_cycle();
        tests_run++;
        if (o_code !== 4'd11 || o_code_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_cycle: got code %0d vld %b expected 11 0", o_code, o_code_vld);
        end
        do_cycle();
        tests_run++;
        if (o_code !== 4'd3 || o_code_vld !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reload: got code %0d vld %b expected 3 1", o_code, o_code_vld);
        end
    endtask

    // Asynchronous reset while locked at code 9
    task automatic test_reset_mid();
        start(4'd9);
        for (int s = 0; s < 8; s++) step_votes(4, (s % 2) == 0, (s % 2) == 1);
        tests_run++;
        if (o_lock !== 1'b1 || o_code !== 4'd9) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_lock: got lock %b code %0d expected 1 9", o_lock, o_code);
        end
        i_rstb = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({o_code, o_code_vld, o_lock, o_sat_hi, o_sat_lo} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h expected 00", {o_code, o_code_vld, o_lock, o_sat_hi, o_sat_lo});
        end
        i_en = 1'b0;
        do_cycle();
        i_rstb = 1'b1;
        do_cycle();
    endtask

`ifdef AIBIO_DLL_CODE_OVRD_EN
    // Override forces the code and suspends tracking
    task automatic test_override();
        start(4'd5);
        i_ovrd_en = 1'b1;
        i_ovrd_code = 4'd12;
        do_cycle();
        tests_run++;
        if (o_code !== 4'd12 || o_code_vld !== 1'b0 || o_lock !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovrd_code: got code %0d vld %b expected 12 0", o_code, o_code_vld);
        end
        step_votes(6, 1'b1, 1'b0);
        tests_run++;
        if (o_code !== 4'd12) begin
            tests_failed++;
            $display("[TB] FAIL ovrd_votes: got %0d expected 12", o_code);
        end
        i_ovrd_en = 1'b0;
        i_code_init = 4'd2;
        do_cycle();
        do_cycle();
        tests_run++;
        if (o_code !== 4'd2 || o_code_vld !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovrd_release: got code %0d vld %b expected 2 1", o_code, o_code_vld);
        end
    endtask
`endif

    // Random votes with a drifting trend, checked against the model
    task automatic test_random();
        int trend;
        logic [7:0] act;
        logic [7:0] expv;
        trend = 1;
        start(4'($urandom_range(0, 15)));
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 5) == 0) trend = -trend;
            i_en = ($urandom_range(0, 99) >= 2);
            i_code_init = 4'($urandom_range(0, 15));
            i_pd_vld = ($urandom_range(0, 9) >= 2);
            if ($urandom_range(0, 9) == 0) begin
                i_pd_up = 1'($urandom); i_pd_dn = 1'($urandom);
            end else begin
                i_pd_up = (trend > 0); i_pd_dn = (trend < 0);
            end
`ifdef AIBIO_DLL_CODE_OVRD_EN
            i_ovrd_en = ($urandom_range(0, 99) == 0);
            i_ovrd_code = 4'($urandom_range(0, 15));
`endif
            do_cycle();
            act = {o_code, o_code_vld, o_lock, o_sat_hi, o_sat_lo};
            expv = exp_vec();
            tests_run++;
            if (act !== expv) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", n, act, expv);
            end
        end
        i_pd_vld = 1'b0;
`ifdef AIBIO_DLL_CODE_OVRD_EN
        i_ovrd_en = 1'b0;
`endif
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        vddcq = 1'b1;
        vss = 1'b0;
        i_en = 1'b0;
        i_code_init = 4'd0;
        i_pd_vld = 1'b0;
        i_pd_up = 1'b0;
        i_pd_dn = 1'b0;
`ifdef AIBIO_DLL_CODE_OVRD_EN
        i_ovrd_en = 1'b0;
        i_ovrd_code = 4'd0;
`endif
        model_reset();
        test_reset();
        test_step_up();
        test_saturation();
        test_lock();
        test_enable_drop();
        test_reset_mid();
`ifdef AIBIO_DLL_CODE_OVRD_EN
        test_override();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
